// File: rtl/mul_booth_pipe_if.sv
// rtl/mul_booth_pipe_if.sv - operand/result handshake bundle for mul_booth_pipe
interface mul_booth_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_a_sgn;
  logic               in_b_sgn;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_a, in_b, in_a_sgn, in_b_sgn, in_tag, out_ready,
    input  in_ready, out_valid, out_prod, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_a_sgn, in_b_sgn, in_tag, out_ready,
    output in_ready, out_valid, out_prod, out_tag
  );
endinterface

// File: rtl/mul_booth_pipe.sv
// rtl/mul_booth_pipe.sv - 3-stage radix-4 Booth multiplier with valid/ready and tag passthrough
// Optional flush input enabled by defining MUL_BOOTH_PIPE_FLUSH_EN.
module mul_booth_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef MUL_BOOTH_PIPE_FLUSH_EN
  input  logic flush,
`endif
  mul_booth_pipe_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int EW = WIDTH + 2;
  localparam int ND = WIDTH / 2 + 1;
  localparam int NR = ND + 2;

  // Each row's MSB is inverted, so the row is worth 2^(2i+EW-1) too much; subtract it all once.
  function automatic logic [PW-1:0] corr_row();
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < ND; i++) begin
      if (2 * i + EW - 1 < PW) c = c - (PW'(1) << (2 * i + EW - 1));
    end
    return c;
  endfunction

  logic             flush_i;
  logic             adv1, adv2, adv3, take;
  logic             v1, v2, v3;
  logic [TAG_W-1:0] tag1, tag2, tag3;
  logic [PW-1:0]    r1 [NR];
  logic [PW-1:0]    pp_c [NR];
  logic [PW-1:0]    s2, c2, s_c, c_c, p3;
  logic [EW-1:0]    a_ext, b_ext;

`ifdef MUL_BOOTH_PIPE_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign adv3          = !v3 || bus.out_ready;
  assign adv2          = !v2 || adv3;
  assign adv1          = !v1 || adv2;
  assign bus.in_ready  = adv1 && !flush_i;
  assign take          = bus.in_valid && bus.in_ready;
  assign bus.out_valid = v3;
  assign bus.out_prod  = p3;
  assign bus.out_tag   = tag3;

  assign a_ext = {{2{bus.in_a_sgn & bus.in_a[WIDTH-1]}}, bus.in_a};
  assign b_ext = {{2{bus.in_b_sgn & bus.in_b[WIDTH-1]}}, bus.in_b};

  // Negative digits use ~M here; the matching +1 lands in the shared neg row at bit 2i.
  always_comb begin
    logic [EW:0]   bw;
    logic [2:0]    trip;
    logic [EW-1:0] m, x;
    logic [PW-1:0] neg_row;
    bw      = {b_ext, 1'b0};
    neg_row = '0;
    trip    = '0;
    m       = '0;
    x       = '0;
    for (int i = 0; i < ND; i++) begin
      trip = bw[2*i+2 -: 3];
      case (trip)
        3'b001, 3'b010, 3'b101, 3'b110: m = a_ext;
        3'b011, 3'b100:                 m = a_ext << 1;
        default:                        m = '0;
      endcase
      x = trip[2] ? ~m : m;
      pp_c[i] = PW'({~x[EW-1], x[EW-2:0]}) << (2 * i);
      neg_row[2*i] = trip[2];
    end
    pp_c[ND]   = neg_row;
    pp_c[ND+1] = corr_row();
  end

  always_comb begin
    logic [PW-1:0] t;
    s_c = r1[0];
    c_c = r1[1];
    t   = '0;
    for (int k = 2; k < NR; k++) begin
      t   = s_c ^ c_c ^ r1[k];
      c_c = ((s_c & c_c) | (s_c & r1[k]) | (c_c & r1[k])) << 1;
      s_c = t;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      tag1 <= '0;
      tag2 <= '0;
      tag3 <= '0;
      s2   <= '0;
      c2   <= '0;
      p3   <= '0;
      for (int i = 0; i < NR; i++) r1[i] <= '0;
    end else if (flush_i) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (adv1) begin
        v1 <= take;
        if (take) begin
          r1   <= pp_c;
          tag1 <= bus.in_tag;
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          s2   <= s_c;
          c2   <= c_c;
          tag2 <= tag1;
        end
      end
      // Result registers load only on a real transfer so out_prod never moves on a bubble.
      if (adv3) begin
        v3 <= v2;
        if (v2) begin
          p3   <= s2 + c2;
          tag3 <= tag2;
        end
      end
    end
  end
endmodule
